fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 156 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmit stage: pops one word from an upstream FIFO when idle and serialises it
// as start / LSB-first data / optional parity / stop at a fixed divider-derived baud.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW  = $clog2(DATA_WIDTH) + 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic                  tx_q, tx_d;
  logic [BaudW-1:0]      baud_q, baud_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;

  logic baud_last;
  logic idx_last;

  assign baud_last = (baud_q == BaudLast);
  assign idx_last  = (idx_q == IdxLast);

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    fifo_rd  = 1'b0;

    case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = '0;
        // Reset gating keeps the FIFO from losing a word while we are held in reset.
        if (!fifo_empty && !reset) begin
          fifo_rd = 1'b1;
          state_d = StFetch;
        end
      end

      StFetch: begin
        // FIFO read data is registered, so it is valid only now, one cycle after the pop.
        shift_d  = fifo_data;
        parity_d = (^fifo_data) ^ PARITY_ODD;
        baud_d   = '0;
        tx_d     = 1'b0;
        state_d  = StStart;
      end

      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IdxW'(1);
          if (idx_last) begin
            if (PARITY_EN) begin
              tx_d    = parity_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            tx_d = shift_d[0];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StParity: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StStop: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      tx_q     <= 1'b1;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances (no parity, even, odd) each fed by a
// small registered-read FIFO model; one instance is observed at a time through sel.
module tb_fifo_uart_tx;

  localparam int Cpb = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] empty;
  logic [2:0] rd;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [7:0] rdata [3];

  logic [7:0] mem [3][16];
  int         wr_ptr [3] = '{0, 0, 0};
  int         rd_ptr [3] = '{0, 0, 0};
  int         pops   [3] = '{0, 0, 0};
  int         cyc = 0;
  logic [1:0] sel;
  int         n_cmp;
  int         n_err;

  logic mon_tx, mon_rd, mon_busy;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 3; i++) empty[i] = (wr_ptr[i] == rd_ptr[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd[i]) begin
        rdata[i]  <= mem[i][rd_ptr[i] % 16];
        rd_ptr[i] <= rd_ptr[i] + 1;
        pops[i]   <= pops[i] + 1;
      end
    end
  end

  always_comb begin
    mon_tx   = tx[sel];
    mon_rd   = rd[sel];
    mon_busy = busy[sel];
  end

  fifo_uart_tx #(
    .CLKS_PER_BIT(Cpb), .DATA_WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset), .fifo_empty(empty[0]), .fifo_data(rdata[0]),
    .fifo_rd(rd[0]), .tx(tx[0]), .busy(busy[0])
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(Cpb), .DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) u_dut_even (
    .clk(clk), .reset(reset), .fifo_empty(empty[1]), .fifo_data(rdata[1]),
    .fifo_rd(rd[1]), .tx(tx[1]), .busy(busy[1])
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(Cpb), .DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)
  ) u_dut_odd (
    .clk(clk), .reset(reset), .fifo_empty(empty[2]), .fifo_data(rdata[2]),
    .fifo_rd(rd[2]), .tx(tx[2]), .busy(busy[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[sel][wr_ptr[sel] % 16] = w;
    wr_ptr[sel] = wr_ptr[sel] + 1;
  endtask

  // Returns the cycle in which fifo_rd is seen high (sampled at negedge), or -1.
  task automatic wait_rd(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mon_rd) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_eq({tag, " pop timeout"}, 32'd0, 32'd1);
    else       check_eq({tag, " busy in pop cycle"}, 32'(mon_busy), 32'd0);
  endtask

  // Called right after wait_rd; walks the FETCH cycle and every line cycle of the frame.
  task automatic check_frame(input string tag, input logic [11:0] exp_bits, input int nbits,
                             input int push_at, input logic [7:0] push_val);
    @(negedge clk);
    check_eq({tag, " fetch tx"}, 32'(mon_tx), 32'd1);
    check_eq({tag, " fetch busy"}, 32'(mon_busy), 32'd1);
    for (int c = 0; c < nbits * Cpb; c++) begin
      @(negedge clk);
      check_eq($sformatf("%s bit%0d tx", tag, c / Cpb), 32'(mon_tx), 32'(exp_bits[c / Cpb]));
      check_eq($sformatf("%s c%0d no pop", tag, c), 32'(mon_rd), 32'd0);
      check_eq($sformatf("%s c%0d busy", tag, c), 32'(mon_busy), 32'd1);
      if (c == push_at) push(push_val);
    end
  endtask

  task automatic idle_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq(tag, {29'd0, mon_tx, mon_rd, mon_busy}, 32'b100);
    end
  endtask

  initial begin
    int t0;
    int t1;
    int t2;
    n_cmp = 0;
    n_err = 0;
    sel   = 2'd0;
    reset = 1'b1;

    // Reset with an empty FIFO, then a long quiet idle.
    repeat (3) begin
      @(negedge clk);
      check_eq("in reset", {29'd0, mon_tx, mon_rd, mon_busy}, 32'b100);
    end
    reset = 1'b0;
    idle_quiet("post reset idle", 50);

    // Single 0xA5 frame.
    @(posedge clk); #1;
    push(8'hA5);
    wait_rd("a5", t0);
    check_frame("a5", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, -1, 8'h00);
    idle_quiet("a5 after", 3);
    check_eq("a5 pops", 32'(pops[0]), 32'd1);

    // Back-to-back 0x00, 0xFF, 0x3C.
    @(posedge clk); #1;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_rd("b2b0", t0);
    check_frame("b2b0", {2'b00, 1'b1, 8'h00, 1'b0}, 10, -1, 8'h00);
    wait_rd("b2b1", t1);
    check_eq("b2b pop period 1", 32'(t1 - t0), 32'd42);
    check_frame("b2b1", {2'b00, 1'b1, 8'hFF, 1'b0}, 10, -1, 8'h00);
    wait_rd("b2b2", t2);
    check_eq("b2b pop period 2", 32'(t2 - t1), 32'd42);
    check_frame("b2b2", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, -1, 8'h00);
    check_eq("b2b fifo drained", 32'(empty[0]), 32'd1);
    idle_quiet("b2b after", 20);
    check_eq("b2b pops", 32'(pops[0]), 32'd4);

    // Reset during data bit 3 of 0x55; 0x66 must follow intact, 0x55 never again.
    @(posedge clk); #1;
    push(8'h55);
    push(8'h66);
    wait_rd("rst55", t0);
    repeat (19) @(negedge clk);
    check_eq("rst 55 bit3 tx", 32'(mon_tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst tx high", 32'(mon_tx), 32'd1);
    check_eq("rst busy low", 32'(mon_busy), 32'd0);
    check_eq("rst rd forced low", 32'(mon_rd), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_rd("rst66", t1);
    check_eq("rst66 pop cycle", 32'(t1 - t0), 32'd21);
    check_frame("rst66", {2'b00, 1'b1, 8'h66, 1'b0}, 10, -1, 8'h00);
    idle_quiet("rst after", 20);
    check_eq("rst pops", 32'(pops[0]), 32'd6);

    // Late fill: word appears during the first stop-bit cycle.
    @(posedge clk); #1;
    push(8'h3C);
    wait_rd("late0", t0);
    check_frame("late0", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 36, 8'h81);
    wait_rd("late1", t1);
    check_eq("late pop period", 32'(t1 - t0), 32'd42);
    check_frame("late1", {2'b00, 1'b1, 8'h81, 1'b0}, 10, -1, 8'h00);
    idle_quiet("late after", 10);
    check_eq("late pops", 32'(pops[0]), 32'd8);

    // Even parity: 0x07 has three ones, so the parity bit is 1.
    sel = 2'd1;
    @(posedge clk); #1;
    push(8'h07);
    wait_rd("par even", t0);
    check_frame("par even", {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 8'h00);
    @(negedge clk);
    check_eq("par even idle after 44", 32'(mon_busy), 32'd0);
    check_eq("par even pops", 32'(pops[1]), 32'd1);

    // Odd parity: same word, parity bit 0.
    sel = 2'd2;
    @(posedge clk); #1;
    push(8'h07);
    wait_rd("par odd", t0);
    check_frame("par odd", {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 8'h00);
    @(negedge clk);
    check_eq("par odd idle after 44", 32'(mon_busy), 32'd0);
    check_eq("par odd pops", 32'(pops[2]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
